// File: rtl/mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
// Shared types and default sizing for the multiplier operand sequencer.
//   state_t          : sequencer FSM states (IDLE, ISSUE, WAIT, RESP)
//   DEFAULT_WIDTH    : operand width, product is twice this
//   DEFAULT_DEPTH    : operand FIFO entries (power of two, >= 2)
//   DEFAULT_TIMEOUT  : WAIT cycles allowed before an op is aborted
// ---------------------------------------------------------------------------
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEFAULT_WIDTH   = 32;
   localparam int DEFAULT_DEPTH   = 4;
   localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mul_seq_if.sv
// ---------------------------------------------------------------------------
// mul_seq_if
// Bundles every non-clock/reset signal of the operand sequencer.
//   producer side : in_valid, in_ready, in_a, in_b
//   consumer side : out_valid, out_ready, out_product, out_error
//   multiplier    : mul_start, mul_a, mul_b, mul_product, mul_done
//   status        : busy
// Modports:
//   master : the sequencer itself
//   slave  : the environment around it (producer, consumer, multiplier)
// ---------------------------------------------------------------------------
interface mul_seq_if #(
   parameter int WIDTH = mul_seq_pkg::DEFAULT_WIDTH
);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_product;
   logic               out_error;
   logic               mul_start;
   logic [WIDTH-1:0]   mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0] mul_product;
   logic               mul_done;
   logic               busy;

   modport master (
      input  in_valid, in_a, in_b, out_ready, mul_product, mul_done,
      output in_ready, out_valid, out_product, out_error, mul_start, mul_a, mul_b, busy
   );

   modport slave (
      output in_valid, in_a, in_b, out_ready, mul_product, mul_done,
      input  in_ready, out_valid, out_product, out_error, mul_start, mul_a, mul_b, busy
   );

endinterface

// File: rtl/mul_seq_fifo.sv
// ---------------------------------------------------------------------------
// mul_seq_fifo
// Synchronous FIFO holding packed operand pairs for the sequencer.
//   clk, reset : clock and asynchronous active-high reset (flushes pointers)
//   push       : write wr_data when not full
//   pop        : discard the head entry when not empty
//   wr_data    : entry to write
//   rd_data    : current head entry (valid while !empty)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mul_seq_fifo #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
   // pointers simply wrap; the separate count tells full from empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array. It needs no reset because the flushed pointers make
   // any leftover contents unreachable.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mul_operand_sequencer
// Feeds a multi-cycle multiplier one operand pair at a time and returns the
// products in order on a valid/ready result port. A multiplier that never
// answers within TIMEOUT WAIT cycles yields an error result with product 0.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; aborts any op and flushes the FIFO
//   bus   : mul_seq_if.master -- operand input, result output, multiplier
//           start/operands/product/done, busy status
// ---------------------------------------------------------------------------
module mul_operand_sequencer
   import mul_seq_pkg::*;
#(
   parameter  int WIDTH   = DEFAULT_WIDTH,
   parameter  int DEPTH   = DEFAULT_DEPTH,
   parameter  int TIMEOUT = DEFAULT_TIMEOUT,
   localparam int CNT_W   = $clog2(TIMEOUT + 1),
   localparam int FCNT_W  = $clog2(DEPTH) + 1
) (
   input logic       clk,
   input logic       reset,
   mul_seq_if.master bus
);

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   wait_cnt;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FCNT_W-1:0]  fifo_count;
   logic [2*WIDTH-1:0] fifo_head;
   logic               load_ops;
   logic               take_result;
   logic               take_timeout;
   logic               release_result;
   logic               start_q;
   logic [WIDTH-1:0]   mul_a_q;
   logic [WIDTH-1:0]   mul_b_q;
   logic               out_valid_q;
   logic               out_error_q;
   logic [2*WIDTH-1:0] out_product_q;

   assign bus.in_ready    = (fifo_count < FCNT_W'(DEPTH));
   assign fifo_push       = bus.in_valid && !fifo_full;
   assign bus.mul_start   = start_q;
   assign bus.mul_a       = mul_a_q;
   assign bus.mul_b       = mul_b_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_error   = out_error_q;
   assign bus.out_product = out_product_q;
   assign bus.busy        = (state != IDLE) || !fifo_empty;

   mul_seq_fifo #(
      .DATA_W (2*WIDTH),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({bus.in_a, bus.in_b}),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // State register for the sequencer FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus the one-cycle strobes that drive the datapath.
   // A done seen while wait_cnt is still 0 belongs to the previous op (the
   // multiplier has not yet seen our start), so it is never taken. Done wins
   // over the timeout if both land in the same cycle.
   always_comb begin
      next_state     = state;
      fifo_pop       = 1'b0;
      load_ops       = 1'b0;
      take_result    = 1'b0;
      take_timeout   = 1'b0;
      release_result = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            fifo_pop   = 1'b1;
            load_ops   = 1'b1;
            next_state = WAIT;
         end
         WAIT: begin
            if ((wait_cnt != '0) && bus.mul_done) begin
               take_result = 1'b1;
               next_state  = RESP;
            end else if (wait_cnt >= CNT_W'(TIMEOUT - 1)) begin
               take_timeout = 1'b1;
               next_state   = RESP;
            end
         end
         RESP: begin
            if (out_valid_q && bus.out_ready) begin
               release_result = 1'b1;
               next_state     = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Wait counter: cleared when an op is issued, then counts WAIT cycles and
   // sticks at TIMEOUT rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (load_ops) begin
         wait_cnt <= '0;
      end else if ((state == WAIT) && (wait_cnt != CNT_W'(TIMEOUT))) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   // Multiplier-facing registers. Start is registered alongside the operands
   // so the multiplier sees the pulse and the new operands in the same cycle;
   // the operands then stay put until the next issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else begin
         start_q <= load_ops;
         if (load_ops) begin
            mul_a_q <= fifo_head[2*WIDTH-1:WIDTH];
            mul_b_q <= fifo_head[WIDTH-1:0];
         end
      end
   end

   // Result registers. They only change on capture or on the consumer
   // handshake, which keeps them stable while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_error_q   <= 1'b0;
         out_product_q <= '0;
      end else if (take_result) begin
         out_valid_q   <= 1'b1;
         out_error_q   <= 1'b0;
         out_product_q <= bus.mul_product;
      end else if (take_timeout) begin
         out_valid_q   <= 1'b1;
         out_error_q   <= 1'b1;
         out_product_q <= '0;
      end else if (release_result) begin
         out_valid_q <= 1'b0;
         out_error_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_operand_sequencer
// Self-checking bench for mul_operand_sequencer with a stub multiplier
// (programmable latency, hang and stale-done modes). A negedge monitor keeps
// an expected-result queue plus FIFO occupancy / in-flight bookkeeping and
// compares the DUT against it every cycle; directed scenarios add literal
// expectations on top, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_mul_operand_sequencer;

   localparam int WIDTH   = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 255;

   typedef struct {
      logic [2*WIDTH-1:0] product;
      logic               error;
   } result_t;

   logic clk;
   logic reset;

   mul_seq_if #(.WIDTH(WIDTH)) bus ();

   mul_operand_sequencer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_compared = 0;
   int n_mismatch = 0;

   // Stub multiplier controls and state
   int               lat = 5;
   bit               hang_mode = 0;
   bit               stale_mode = 0;
   int               stub_rem;
   logic [WIDTH-1:0] stub_a;
   logic [WIDTH-1:0] stub_b;

   // Reference model state
   result_t            exp_q[$];
   logic [2*WIDTH-1:0] got_log[$];
   int                 occ = 0;
   bit                 inflight = 0;
   int                 cycle = 0;
   int                 start_cycle = 0;
   int                 last_latency = 0;
   int                 starts_seen = 0;
   int                 results_seen = 0;
   bit                 stale_at_start = 0;
   logic [2*WIDTH-1:0] last_product = '0;
   logic               last_error = 1'b0;
   bit                 prev_valid = 0;
   bit                 prev_ready = 0;
   bit                 prev_done = 0;
   logic [2*WIDTH-1:0] prev_product = '0;
   logic               prev_error = 1'b0;
   bit                 rand_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] wa;
      logic [2*WIDTH-1:0] wb;
      wa = {{WIDTH{1'b0}}, a};
      wb = {{WIDTH{1'b0}}, b};
      return wa * wb;
   endfunction

   task automatic checkOutput(input string name, input logic [2*WIDTH-1:0] got, input logic [2*WIDTH-1:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatch++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Push one operand pair, holding in_valid until it is accepted.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int tries = 0;
      bit acc = 0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      while (!acc && tries < 1000) begin
         @(negedge clk);
         acc = bus.in_ready && !reset;
         @(posedge clk);
         #1;
         tries++;
      end
      bus.in_valid = 1'b0;
      if (!acc) checkOutput("push_timeout", 0, 1);
   endtask

   task automatic waitDrain();
      int tries = 0;
      while (!(exp_q.size() == 0 && occ == 0 && !inflight) && tries < 3000) begin
         @(posedge clk);
         #1;
         tries++;
      end
      if (tries >= 3000) checkOutput("drain_timeout", 0, 1);
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stub multiplier: captures operands on start and clears done, then raises
   // done with the product lat cycles later. Normally done is a single-cycle
   // pulse; in stale mode it stays high until the next start. Hang mode never
   // answers.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mul_done    <= 1'b0;
         bus.mul_product <= '0;
         stub_rem        <= 0;
      end else if (bus.mul_start) begin
         stub_a       <= bus.mul_a;
         stub_b       <= bus.mul_b;
         bus.mul_done <= 1'b0;
         stub_rem     <= hang_mode ? 0 : lat;
      end else if (stub_rem != 0) begin
         stub_rem <= stub_rem - 1;
         if (stub_rem == 1) begin
            bus.mul_done    <= 1'b1;
            bus.mul_product <= ref_mul(stub_a, stub_b);
         end
      end else if (!stale_mode) begin
         bus.mul_done <= 1'b0;
      end
   end

   // Compare process: tracks accepted pushes, issues and results, and checks
   // the DUT every cycle against the expected queue and occupancy counts.
   always @(negedge clk) begin
      result_t e;
      cycle++;
      if (reset) begin
         exp_q.delete();
         occ        = 0;
         inflight   = 0;
         prev_valid = 0;
         prev_ready = 0;
         prev_done  = 0;
      end else begin
         if (bus.mul_start) begin
            checkOutput("no_overlap", inflight, 0);
            occ--;
            inflight       = 1;
            start_cycle    = cycle;
            stale_at_start = bus.mul_done;
            starts_seen++;
         end
         checkOutput("in_ready", bus.in_ready, occ < DEPTH);
         checkOutput("busy", bus.busy, (occ > 0) || inflight);
         checkOutput("valid_without_op", bus.out_valid && !inflight, 0);
         if (prev_valid && !prev_ready) begin
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_product", bus.out_product, prev_product);
            checkOutput("hold_error", bus.out_error, prev_error);
         end
         if (bus.out_valid && !prev_valid) begin
            last_latency = cycle - start_cycle;
            if (!bus.out_error) checkOutput("done_latency", prev_done, 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("product", bus.out_product, e.product);
               checkOutput("error", bus.out_error, e.error);
            end
            last_product = bus.out_product;
            last_error   = bus.out_error;
            got_log.push_back(bus.out_product);
            results_seen++;
            inflight = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            e.error   = hang_mode;
            e.product = hang_mode ? '0 : ref_mul(bus.in_a, bus.in_b);
            exp_q.push_back(e);
            occ++;
         end
         prev_valid   = bus.out_valid;
         prev_ready   = bus.out_ready;
         prev_done    = bus.mul_done;
         prev_product = bus.out_product;
         prev_error   = bus.out_error;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0;
      int r0;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;

      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      bus.out_ready = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      $display("[TB] reset values");
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_out_error", bus.out_error, 0);
      checkOutput("rst_out_product", bus.out_product, 0);
      checkOutput("rst_mul_start", bus.mul_start, 0);
      checkOutput("rst_busy", bus.busy, 0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 1. single op 3x5
      $display("[TB] single op");
      s0 = starts_seen;
      lat = 5;
      applyStimulus(32'd3, 32'd5);
      waitDrain();
      checkOutput("t1_starts", starts_seen - s0, 1);
      checkOutput("t1_product", last_product, 64'd15);
      checkOutput("t1_error", last_error, 0);
      checkOutput("t1_in_ready", bus.in_ready, 1);

      // 2. back-pressure: fill the FIFO while the consumer stalls
      $display("[TB] back-pressure");
      bus.out_ready = 1'b0;
      got_log.delete();
      for (int i = 1; i <= 5; i++) applyStimulus(i, i);
      idleCycles(20);
      checkOutput("t2_in_ready_full", bus.in_ready, 0);
      checkOutput("t2_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      waitDrain();
      checkOutput("t2_count", got_log.size(), 5);
      if (got_log.size() == 5) begin
         for (int i = 0; i < 5; i++) checkOutput("t2_order", got_log[i], (i + 1) * (i + 1));
      end

      // 3. extreme operands
      $display("[TB] extreme operands");
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDrain();
      checkOutput("t3_max", last_product, 64'hFFFF_FFFE_0000_0001);
      applyStimulus(32'd0, 32'hDEAD_BEEF);
      waitDrain();
      checkOutput("t3_zero", last_product, 64'd0);
      checkOutput("t3_zero_err", last_error, 0);

      // 4. hung multiplier
      $display("[TB] timeout");
      hang_mode = 1;
      applyStimulus(32'd11, 32'd13);
      waitDrain();
      hang_mode = 0;
      checkOutput("t4_error", last_error, 1);
      checkOutput("t4_product", last_product, 0);
      checkOutput("t4_latency", last_latency, TIMEOUT);
      applyStimulus(32'd12, 32'd12);
      waitDrain();
      checkOutput("t4_next_product", last_product, 64'd144);
      checkOutput("t4_next_error", last_error, 0);

      // 5. stale done from the previous op
      $display("[TB] stale done");
      stale_mode = 1;
      lat = 3;
      applyStimulus(32'd3, 32'd5);
      waitDrain();
      applyStimulus(32'd7, 32'd9);
      waitDrain();
      checkOutput("t5_stale_present", stale_at_start, 1);
      checkOutput("t5_product", last_product, 64'd63);
      stale_mode = 0;
      lat = 5;

      // 6. reset while an op waits with pairs queued
      $display("[TB] reset mid-op");
      lat = 100;
      applyStimulus(32'd9, 32'd8);
      applyStimulus(32'd2, 32'd3);
      applyStimulus(32'd4, 32'd5);
      idleCycles(6);
      checkOutput("t6_pre_mul_a", bus.mul_a, 32'd9);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_out_valid", bus.out_valid, 0);
      checkOutput("t6_mul_start", bus.mul_start, 0);
      checkOutput("t6_mul_a", bus.mul_a, 0);
      checkOutput("t6_in_ready", bus.in_ready, 1);
      checkOutput("t6_busy", bus.busy, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      lat = 5;
      s0 = starts_seen;
      r0 = results_seen;
      idleCycles(20);
      checkOutput("t6_no_start", starts_seen - s0, 0);
      checkOutput("t6_no_result", results_seen - r0, 0);
      applyStimulus(32'd7, 32'd6);
      waitDrain();
      checkOutput("t6_product", last_product, 64'd42);

      // 7. randomized traffic with random consumer stalls
      $display("[TB] random traffic");
      fork
         begin
            for (int n = 0; n < 60; n++) begin
               lat = $urandom_range(1, 8);
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               ra = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
               rb = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
               applyStimulus(ra, rb);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
